// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (ibus/dbus masters), the arbiter and the shared
// 64-bit memory port. The arbiter uses the slave view; the surrounding core and
// memory use the master view.
interface mem_port_arbiter_if;
    // Instruction-fetch bus
    logic        ibus_ena;
    logic [63:0] ibus_addr;
    logic        ibus_valid1;
    logic        ibus_valid2;
    logic [31:0] ibus_rdata1;
    logic [31:0] ibus_rdata2;
    // Data bus
    logic        dbus_ena;
    logic [7:0]  dbus_wea;
    logic [2:0]  dbus_rlen;
    logic [63:0] dbus_addr;
    logic [63:0] dbus_wdata;
    logic [63:0] dbus_rdata;
    logic        dbus_stall;
    // Downstream memory port
    logic        mem_req;
    logic        mem_gnt;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wea;
    logic [2:0]  mem_rlen;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport slave (
        input  ibus_ena, ibus_addr,
        output ibus_valid1, ibus_valid2, ibus_rdata1, ibus_rdata2,
        input  dbus_ena, dbus_wea, dbus_rlen, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_stall,
        output mem_req, mem_addr, mem_wea, mem_rlen, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output ibus_ena, ibus_addr,
        input  ibus_valid1, ibus_valid2, ibus_rdata1, ibus_rdata2,
        output dbus_ena, dbus_wea, dbus_rlen, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_stall,
        input  mem_req, mem_addr, mem_wea, mem_rlen, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data accesses.
// One transaction is outstanding at a time; dbus wins ties, but after
// MAX_D_STREAK consecutive dbus grants with a fetch waiting, the fetch goes next.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);
    localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_REQ  = 3'd1;
    localparam logic [2:0] ST_I_WAIT = 3'd2;
    localparam logic [2:0] ST_D_REQ  = 3'd3;
    localparam logic [2:0] ST_D_WAIT = 3'd4;

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic                mem_req_r;
    logic [STREAK_W-1:0] d_streak_r;
    logic [63:0]         req_addr_r;
    logic [7:0]          req_wea_r;
    logic [2:0]          req_rlen_r;
    logic [63:0]         req_wdata_r;
    logic                fetch_hi_r;

    logic grant_d_s;
    logic grant_i_s;
    logic streak_full_s;
    logic fetch_match_s;
    logic rsp_hit_s;
    logic d_done_s;

    assign streak_full_s = (d_streak_r == STREAK_MAX);
    // The fetch is still wanted only if the core asks for the very word it was issued for.
    assign fetch_match_s = (bus.ibus_addr == {req_addr_r[63:3], fetch_hi_r, 2'b00});
    assign rsp_hit_s     = (state_r == ST_I_WAIT) & bus.mem_rvalid & bus.ibus_ena & fetch_match_s;
    assign d_done_s      = (state_r == ST_D_WAIT) & bus.mem_rvalid;

    // Arbitration decision taken in IDLE: dbus first unless the fetch has waited long enough
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.dbus_ena && !(bus.ibus_ena && streak_full_s)) begin
                grant_d_s = 1'b1;
            end else if (bus.ibus_ena) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Sequencer next state: request until granted, then wait for the response
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = ST_D_REQ;
                end else if (grant_i_s) begin
                    state_nxt_s = ST_I_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_I_REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt_s = ST_I_WAIT;
                end else begin
                    state_nxt_s = ST_I_REQ;
                end
            end
            ST_I_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_I_WAIT;
                end
            end
            ST_D_REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt_s = ST_D_WAIT;
                end else begin
                    state_nxt_s = ST_D_REQ;
                end
            end
            ST_D_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_D_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and flopped request strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mem_req_r <= (state_nxt_s == ST_I_REQ) || (state_nxt_s == ST_D_REQ);
        end
    end

    // Capture the winning request when leaving IDLE; fetches go out 8-byte aligned
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_addr_r  <= 64'h0;
            req_wea_r   <= 8'h00;
            req_rlen_r  <= 3'd0;
            req_wdata_r <= 64'h0;
            fetch_hi_r  <= 1'b0;
        end else if (grant_d_s) begin
            req_addr_r  <= bus.dbus_addr;
            req_wea_r   <= bus.dbus_wea;
            req_rlen_r  <= bus.dbus_rlen;
            req_wdata_r <= bus.dbus_wdata;
            fetch_hi_r  <= 1'b0;
        end else if (grant_i_s) begin
            req_addr_r  <= {bus.ibus_addr[63:3], 3'b000};
            req_wea_r   <= 8'h00;
            req_rlen_r  <= 3'd7;
            req_wdata_r <= 64'h0;
            fetch_hi_r  <= bus.ibus_addr[2];
        end
    end

    // Count dbus wins over a waiting fetch; any fetch grant clears the count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_streak_r <= '0;
        end else if (grant_i_s) begin
            d_streak_r <= '0;
        end else if (grant_d_s && bus.ibus_ena && !streak_full_s) begin
            d_streak_r <= d_streak_r + STREAK_W'(1);
        end
    end

    assign bus.mem_req     = mem_req_r;
    assign bus.mem_addr    = req_addr_r;
    assign bus.mem_wea     = req_wea_r;
    assign bus.mem_rlen    = req_rlen_r;
    assign bus.mem_wdata   = req_wdata_r;

    assign bus.ibus_valid1 = rsp_hit_s;
    assign bus.ibus_valid2 = rsp_hit_s & ~fetch_hi_r;
    assign bus.ibus_rdata1 = !rsp_hit_s ? 32'h0 :
                             (fetch_hi_r ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]);
    assign bus.ibus_rdata2 = (rsp_hit_s & ~fetch_hi_r) ? bus.mem_rdata[63:32] : 32'h0;

    assign bus.dbus_stall  = bus.dbus_ena & ~d_done_s;
    assign bus.dbus_rdata  = d_done_s ? bus.mem_rdata : 64'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: acts as core and memory, runs directed scenarios
// and a randomized phase, and checks every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int MAXD = 4;

    logic clk = 1'b0;
    logic resetn;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_STREAK(MAXD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int          gnt_cfg = 0;     // -1: random 0..3
    int          rv_cfg = 0;      // -1: random 0..3
    bit          spur_en = 1'b0;
    bit          resp_fixed = 1'b1;
    logic [63:0] resp_data_cfg = 64'h0;
    bit          mem_outst = 1'b0;
    bit          rv_real = 1'b0;
    int          gcnt = -1;
    int          rcnt = 0;
    int          rv_count = 0;

    initial begin
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata = resp_fixed ? resp_data_cfg : {$urandom, $urandom};
            rv_real = 1'b0;
            if (!resetn) begin
                mem_outst = 1'b0;
                gcnt = -1;
            end else begin
                if (mem_outst) begin
                    if (rcnt == 0) begin
                        bus.mem_rvalid = 1'b1;
                        rv_real = 1'b1;
                    end else begin
                        rcnt = rcnt - 1;
                    end
                end else if (spur_en && $urandom_range(0, 7) == 0) begin
                    bus.mem_rvalid = 1'b1;
                end
                if (bus.mem_req) begin
                    if (gcnt < 0) gcnt = (gnt_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_cfg;
                    if (gcnt == 0) bus.mem_gnt = 1'b1;
                    else gcnt = gcnt - 1;
                end
            end
            @(negedge clk);
            if (resetn) begin
                if (rv_real) begin
                    mem_outst = 1'b0;
                    rv_count = rv_count + 1;
                end
                if (bus.mem_req && bus.mem_gnt) begin
                    mem_outst = 1'b1;
                    gcnt = -1;
                    rcnt = (rv_cfg < 0) ? int'($urandom_range(0, 3)) : rv_cfg;
                end
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    int          m_kind = 0;      // 0 nothing in flight, 1 fetch, 2 data
    bit          m_granted = 1'b0;
    int          m_streak = 0;
    logic [63:0] m_faddr, m_addr, m_wdata;
    logic [7:0]  m_wea;
    logic [2:0]  m_rlen;

    initial begin
        bit exp_req, exp_hit, exp_v2, exp_dd;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_kind = 0;
                m_granted = 1'b0;
                m_streak = 0;
            end else begin
                exp_req = (m_kind != 0) && !m_granted;
                exp_hit = (m_kind == 1) && m_granted && bus.mem_rvalid && bus.ibus_ena
                          && (bus.ibus_addr == m_faddr);
                exp_v2  = exp_hit && (m_faddr[2] == 1'b0);
                exp_dd  = (m_kind == 2) && m_granted && bus.mem_rvalid;

                check("mem_req", 64'(bus.mem_req), 64'(exp_req));
                if (exp_req) begin
                    check("mem_addr", bus.mem_addr, m_addr);
                    check("mem_wea", 64'(bus.mem_wea), 64'(m_wea));
                    check("mem_rlen", 64'(bus.mem_rlen), 64'(m_rlen));
                    if (m_kind == 2) check("mem_wdata", bus.mem_wdata, m_wdata);
                end
                check("ibus_valid1", 64'(bus.ibus_valid1), 64'(exp_hit));
                check("ibus_valid2", 64'(bus.ibus_valid2), 64'(exp_v2));
                if (exp_hit)
                    check("ibus_rdata1", 64'(bus.ibus_rdata1),
                          m_faddr[2] ? 64'(bus.mem_rdata[63:32]) : 64'(bus.mem_rdata[31:0]));
                if (exp_v2) check("ibus_rdata2", 64'(bus.ibus_rdata2), 64'(bus.mem_rdata[63:32]));
                check("dbus_stall", 64'(bus.dbus_stall), 64'(bus.dbus_ena && !exp_dd));
                if (exp_dd) check("dbus_rdata", bus.dbus_rdata, bus.mem_rdata);

                // advance the model to what the coming clock edge does
                if (m_kind == 0) begin
                    if (bus.dbus_ena && !(bus.ibus_ena && m_streak == MAXD)) begin
                        m_kind = 2;
                        m_addr = bus.dbus_addr;
                        m_wea = bus.dbus_wea;
                        m_rlen = bus.dbus_rlen;
                        m_wdata = bus.dbus_wdata;
                        if (bus.ibus_ena && m_streak < MAXD) m_streak = m_streak + 1;
                    end else if (bus.ibus_ena) begin
                        m_kind = 1;
                        m_faddr = bus.ibus_addr;
                        m_addr = bus.ibus_addr & ~64'h7;
                        m_wea = 8'h00;
                        m_rlen = 3'd7;
                        m_streak = 0;
                    end
                end else if (!m_granted) begin
                    if (bus.mem_gnt) m_granted = 1'b1;
                end else if (bus.mem_rvalid) begin
                    m_kind = 0;
                    m_granted = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fetch_once(input logic [63:0] a, output int lat, output logic first_req,
                              output logic v2, output logic [31:0] r1, output logic [31:0] r2,
                              output logic [63:0] maddr);
        @(posedge clk);
        #1;
        bus.ibus_ena = 1'b1;
        bus.ibus_addr = a;
        lat = -1; first_req = 1'b0; v2 = 1'b0; r1 = 32'h0; r2 = 32'h0; maddr = 64'h0;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) first_req = bus.mem_req;
            if (bus.mem_req) maddr = bus.mem_addr;
            if (bus.ibus_valid1) begin
                lat = c;
                v2 = bus.ibus_valid2;
                r1 = bus.ibus_rdata1;
                r2 = bus.ibus_rdata2;
            end
        end
        @(posedge clk);
        #1;
        bus.ibus_ena = 1'b0;
    endtask

    task automatic dbus_txn(input logic [63:0] a, input logic [7:0] w, input logic [63:0] wd,
                            output int done_c, output logic [63:0] rd, output int req_n,
                            output int stall_n, output bit stable);
        @(posedge clk);
        #1;
        bus.dbus_ena = 1'b1;
        bus.dbus_addr = a;
        bus.dbus_wea = w;
        bus.dbus_wdata = wd;
        bus.dbus_rlen = 3'd3;
        done_c = -1; rd = 64'h0; req_n = 0; stall_n = 0; stable = 1'b1;
        for (int c = 0; c < 30 && done_c < 0; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                req_n = req_n + 1;
                if (bus.mem_addr != a || bus.mem_wea != w || bus.mem_wdata != wd) stable = 1'b0;
            end
            if (!bus.dbus_stall) begin
                done_c = c;
                rd = bus.dbus_rdata;
            end else begin
                stall_n = stall_n + 1;
            end
        end
        @(posedge clk);
        #1;
        bus.dbus_ena = 1'b0;
        bus.dbus_wea = 8'h00;
    endtask

    function automatic logic [63:0] rand_iaddr();
        rand_iaddr = 64'h1000 + 64'(4 * $urandom_range(0, 15));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat, done_c, req_n, stall_n, nrec;
        logic first_req, v2, prev_req, g, vseen, i_done, d_done;
        logic [31:0] r1, r2;
        logic [63:0] maddr, rd;
        bit stable;
        string order;

        resetn = 1'b0;
        bus.ibus_ena = 1'b0;
        bus.ibus_addr = 64'h0;
        bus.dbus_ena = 1'b0;
        bus.dbus_wea = 8'h00;
        bus.dbus_rlen = 3'd0;
        bus.dbus_addr = 64'h0;
        bus.dbus_wdata = 64'h0;
        resp_data_cfg = 64'h22221111_33334444;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst mem_req", 64'(bus.mem_req), 64'h0);
        check("rst mem_wea", 64'(bus.mem_wea), 64'h0);
        check("rst mem_addr", bus.mem_addr, 64'h0);
        check("rst valid1", 64'(bus.ibus_valid1), 64'h0);
        check("rst valid2", 64'(bus.ibus_valid2), 64'h0);
        check("rst dbus_stall", 64'(bus.dbus_stall), 64'h0);
        check("rst rdata1", 64'(bus.ibus_rdata1), 64'h0);
        check("rst rdata2", 64'(bus.ibus_rdata2), 64'h0);
        check("rst dbus_rdata", bus.dbus_rdata, 64'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // single aligned fetch, minimum latency
        fetch_once(64'h1000, lat, first_req, v2, r1, r2, maddr);
        check("fetch latency", 64'(lat), 64'd2);
        check("fetch req not same cycle", 64'(first_req), 64'h0);
        check("fetch valid2", 64'(v2), 64'h1);
        check("fetch rdata1", 64'(r1), 64'h33334444);
        check("fetch rdata2", 64'(r2), 64'h22221111);
        check("fetch mem_addr", maddr, 64'h1000);

        // fetch of the upper word
        fetch_once(64'h1004, lat, first_req, v2, r1, r2, maddr);
        check("mis latency", 64'(lat), 64'd2);
        check("mis valid2", 64'(v2), 64'h0);
        check("mis rdata1", 64'(r1), 64'h22221111);
        check("mis mem_addr", maddr, 64'h1000);

        // dbus write with delayed grant
        gnt_cfg = 3;
        dbus_txn(64'h2000, 8'hFF, 64'hDEAD, done_c, rd, req_n, stall_n, stable);
        check("wr req cycles", 64'(req_n), 64'd4);
        check("wr fields stable", 64'(stable), 64'h1);
        check("wr done cycle", 64'(done_c), 64'd5);
        check("wr stall cycles", 64'(stall_n), 64'd5);
        gnt_cfg = 0;

        // contention: both buses request continuously
        @(posedge clk);
        #1;
        bus.ibus_ena = 1'b1;
        bus.ibus_addr = 64'h4000;
        bus.dbus_ena = 1'b1;
        bus.dbus_wea = 8'hFF;
        bus.dbus_addr = 64'h5000;
        bus.dbus_wdata = 64'h1234;
        order = "";
        prev_req = 1'b0;
        nrec = 0;
        for (int c = 0; c < 200 && nrec < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                order = {order, (bus.mem_wea == 8'hFF) ? "D" : "I"};
                nrec = nrec + 1;
            end
            prev_req = bus.mem_req;
            i_done = bus.ibus_valid1;
            d_done = bus.dbus_ena && !bus.dbus_stall;
            @(posedge clk);
            #1;
            if (i_done) bus.ibus_addr = bus.ibus_addr + 64'h8;
            if (d_done) bus.dbus_addr = bus.dbus_addr + 64'h8;
        end
        checks = checks + 1;
        if (order != "DDDDIDDDDI") begin
            errors = errors + 1;
            $display("FAIL grant_order: got %s expected DDDDIDDDDI", order);
        end
        bus.dbus_ena = 1'b0;
        bus.dbus_wea = 8'h00;
        g = 1'b0;
        for (int c = 0; c < 20 && !g; c++) begin
            @(negedge clk);
            if (bus.ibus_valid1) g = 1'b1;
        end
        check("contention drain", 64'(g), 64'h1);
        @(posedge clk);
        #1;
        bus.ibus_ena = 1'b0;

        // flush: fetch abandoned while waiting for the response
        rv_cfg = 2;
        @(posedge clk);
        #1;
        bus.ibus_ena = 1'b1;
        bus.ibus_addr = 64'h3000;
        g = 1'b0;
        for (int c = 0; c < 20 && !g; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_gnt) g = 1'b1;
        end
        nrec = rv_count;
        @(posedge clk);
        #1;
        bus.ibus_ena = 1'b0;
        vseen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.ibus_valid1 || bus.ibus_valid2) vseen = 1'b1;
        end
        check("flush granted", 64'(g), 64'h1);
        check("flush no valid", 64'(vseen), 64'h0);
        check("flush rsp arrived", 64'(rv_count - nrec), 64'd1);
        rv_cfg = 0;
        resp_data_cfg = 64'h0BAD_F00D_CAFE_0001;
        dbus_txn(64'h6000, 8'h00, 64'h0, done_c, rd, req_n, stall_n, stable);
        check("post-flush done cycle", 64'(done_c), 64'd2);
        check("post-flush rdata", rd, 64'h0BAD_F00D_CAFE_0001);

        // reset in the middle of a data wait
        rv_cfg = 5;
        @(posedge clk);
        #1;
        bus.dbus_ena = 1'b1;
        bus.dbus_addr = 64'h7000;
        bus.dbus_wea = 8'h00;
        g = 1'b0;
        for (int c = 0; c < 20 && !g; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_gnt) g = 1'b1;
        end
        @(posedge clk);
        #3;
        check("pre-reset mem_addr", bus.mem_addr, 64'h7000);
        resetn = 1'b0;
        bus.dbus_ena = 1'b0;
        #1;
        check("async rst mem_req", 64'(bus.mem_req), 64'h0);
        check("async rst mem_addr", bus.mem_addr, 64'h0);
        check("async rst stall", 64'(bus.dbus_stall), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        rv_cfg = 1;
        resp_data_cfg = 64'hA5A5_0123_4567_89AB;
        dbus_txn(64'h7008, 8'h00, 64'h0, done_c, rd, req_n, stall_n, stable);
        check("post-reset done cycle", 64'(done_c), 64'd3);
        check("post-reset rdata", rd, 64'hA5A5_0123_4567_89AB);

        // randomized phase, checked by the model every cycle
        gnt_cfg = -1;
        rv_cfg = -1;
        spur_en = 1'b1;
        resp_fixed = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_done = bus.ibus_ena && bus.ibus_valid1;
            d_done = bus.dbus_ena && !bus.dbus_stall;
            @(posedge clk);
            #1;
            if (bus.ibus_ena) begin
                if (i_done) begin
                    if ($urandom_range(0, 1) == 0) bus.ibus_ena = 1'b0;
                    else bus.ibus_addr = rand_iaddr();
                end else begin
                    case ($urandom_range(0, 15))
                        0: bus.ibus_ena = 1'b0;
                        1: bus.ibus_addr = rand_iaddr();
                        default: bus.ibus_ena = 1'b1;
                    endcase
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.ibus_ena = 1'b1;
                bus.ibus_addr = rand_iaddr();
            end
            if (!bus.dbus_ena || d_done) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.dbus_ena = 1'b1;
                    bus.dbus_wea = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
                    bus.dbus_rlen = 3'($urandom);
                    bus.dbus_addr = {$urandom, $urandom};
                    bus.dbus_wdata = {$urandom, $urandom};
                end else begin
                    bus.dbus_ena = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
